// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin hold arbiter.
// Width helpers keep the port and counter widths consistent between the top and the selector.
package arb_pkg;

   localparam int MAX_N     = 16;
   localparam int MAX_IDX_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Wide enough to hold MAX_HOLD-1 without wrapping.
   function automatic int cnt_width(input int max_hold);
      return $clog2(max_hold) + 1;
   endfunction

   function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] onehot);
      logic [MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_N; i++) begin
         if (onehot[i]) idx = idx | MAX_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first eligible request at or after ptr, wrapping modulo N.
// Eligible requests are rotated down by ptr, the lowest set bit is isolated, then rotated back.
module rr_priority_select
   import arb_pkg::*;
#(
   parameter  int N  = 4,
   localparam int PW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  mask,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic          found
);

   logic [N-1:0]   elig;
   logic [2*N-1:0] rot_dbl;
   logic [N-1:0]   rot;
   logic [N-1:0]   pick_rot;
   logic [2*N-1:0] back_dbl;

   always_comb begin
      elig     = req & ~mask;
      rot_dbl  = {elig, elig} >> ptr;
      rot      = rot_dbl[N-1:0];
      pick_rot = rot & (-rot);
      back_dbl = {pick_rot, pick_rot} << ptr;
      grant    = back_dbl[2*N-1:N];
      found    = |rot;
   end

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with grant hold: the holder keeps GNT while it requests,
// but is rotated out after MAX_HOLD cycles whenever someone else is waiting.
module rr_hold_arbiter
   import arb_pkg::*;
#(
   parameter  int N        = 4,
   parameter  int MAX_HOLD = 4,
   localparam int IDW      = idx_width(N),
   localparam int HW       = cnt_width(MAX_HOLD)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   REQ,
   output logic [N-1:0]   GNT,
   output logic           GNT_VALID,
   output logic [IDW-1:0] GNT_ID
);

   arb_state_t     state, state_n;
   logic [IDW-1:0] ptr, ptr_n;
   logic [HW-1:0]  hold_cnt, hold_n;
   logic [N-1:0]   gnt_n;
   logic [IDW-1:0] next_after_holder;
   logic [N-1:0]   sel_mask;
   logic [IDW-1:0] sel_ptr;
   logic [N-1:0]   sel_gnt;
   logic           sel_found;
   logic           holder_req;

   // While busy the holder is masked and the search starts just past it.
   always_comb begin
      next_after_holder = (GNT_ID == IDW'(N - 1)) ? '0 : GNT_ID + 1'b1;
      sel_mask          = (state == BUSY) ? GNT : '0;
      sel_ptr           = (state == BUSY) ? next_after_holder : ptr;
   end

   rr_priority_select #(.N(N)) u_select (
      .req   (REQ),
      .mask  (sel_mask),
      .ptr   (sel_ptr),
      .grant (sel_gnt),
      .found (sel_found)
   );

   // NOTE: every variable written here is defaulted first, so no path can infer a latch.
   always_comb begin
      state_n    = state;
      ptr_n      = ptr;
      hold_n     = hold_cnt;
      gnt_n      = GNT;
      holder_req = |(REQ & GNT);
      case (state)
         IDLE: begin
            if (sel_found) begin
               gnt_n   = sel_gnt;
               state_n = BUSY;
               hold_n  = '0;
            end
         end
         BUSY: begin
            if (!holder_req) begin
               ptr_n   = next_after_holder;
               hold_n  = '0;
               gnt_n   = sel_gnt;
               state_n = sel_found ? BUSY : IDLE;
            end else if (hold_cnt == HW'(MAX_HOLD - 1)) begin
               hold_n = '0;
               if (sel_found) begin
                  gnt_n = sel_gnt;
                  ptr_n = next_after_holder;
               end
            end else begin
               hold_n = hold_cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; the combinational blocks above use blocking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         hold_cnt  <= '0;
         GNT       <= '0;
         GNT_VALID <= 1'b0;
         GNT_ID    <= '0;
      end else begin
         state     <= state_n;
         ptr       <= ptr_n;
         hold_cnt  <= hold_n;
         GNT       <= gnt_n;
         GNT_VALID <= |gnt_n;
         GNT_ID    <= IDW'(onehot_to_idx(MAX_N'(gnt_n)));
      end
   end

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed bench for rr_hold_arbiter: a cycle-level model of holder/pointer/hold time
// is checked every cycle, plus hand-computed grant literals along the directed sequence.
module tb_rr_hold_arbiter;

   localparam int N        = 4;
   localparam int MAX_HOLD = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] REQ = '0;
   logic [N-1:0] GNT;
   logic         GNT_VALID;
   logic [1:0]   GNT_ID;

   int vectors     = 0;
   int miscompares = 0;

   // Model: who holds the grant, where the search starts, how long the current hold has run.
   int m_holder = -1;
   int m_ptr    = 0;
   int m_held   = 0;

   always #5 clk = ~clk;

   rr_hold_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
      .clk       (clk),
      .rst       (rst),
      .REQ       (REQ),
      .GNT       (GNT),
      .GNT_VALID (GNT_VALID),
      .GNT_ID    (GNT_ID)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int first_req(input logic [N-1:0] r, input int start, input int excl);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (start + k) % N;
         if (i != excl && r[i]) return i;
      end
      return -1;
   endfunction

   function automatic bit others_req(input logic [N-1:0] r, input int h);
      for (int i = 0; i < N; i++) begin
         if (i != h && r[i]) return 1'b1;
      end
      return 1'b0;
   endfunction

   // Compare process: advance the model with the REQ seen at the edge, then check just after it.
   always @(posedge clk) begin
      logic [N-1:0] r;
      logic [N-1:0] exp_g;
      int           h;
      r = REQ;
      if (rst) begin
         m_holder = -1;
         m_ptr    = 0;
         m_held   = 0;
      end else if (m_holder < 0) begin
         m_holder = first_req(r, m_ptr, -1);
         m_held   = (m_holder >= 0) ? 1 : 0;
      end else if (!r[m_holder]) begin
         h        = m_holder;
         m_ptr    = (h + 1) % N;
         m_holder = first_req(r, m_ptr, h);
         m_held   = (m_holder >= 0) ? 1 : 0;
      end else if (m_held == MAX_HOLD) begin
         if (others_req(r, m_holder)) begin
            h        = m_holder;
            m_ptr    = (h + 1) % N;
            m_holder = first_req(r, m_ptr, h);
         end
         m_held = 1;
      end else begin
         m_held++;
      end
      #1;
      exp_g = '0;
      if (m_holder >= 0) exp_g[m_holder] = 1'b1;
      check("model_gnt", 32'(GNT), 32'(exp_g));
      check("model_gnt_valid", 32'(GNT_VALID), 32'(m_holder >= 0));
      check("model_gnt_id", 32'(GNT_ID), (m_holder >= 0) ? 32'(m_holder) : 32'd0);
      check("gnt_onehot0", 32'($onehot0(GNT)), 32'd1);
      check("gnt_subset_of_req", 32'(GNT & ~r), 32'd0);
   end

   // Drive REQ away from the active edge, then land just after the edge that samples it.
   task automatic tick(input logic [N-1:0] r);
      @(negedge clk);
      REQ = r;
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [N-1:0] e;

      // Reset held with no requests.
      repeat (5) tick(4'b0000);
      check("reset_gnt", 32'(GNT), 32'd0);
      check("reset_valid", 32'(GNT_VALID), 32'd0);
      check("reset_id", 32'(GNT_ID), 32'd0);

      @(negedge clk);
      rst = 1'b0;

      // All requesting: four cycles each, rotating 0,1,2,3, then back to 0.
      for (int t = 0; t < 20; t++) begin
         tick(4'b1111);
         e = 4'b0001 << ((t / 4) % 4);
         check("rotate_gnt", 32'(GNT), 32'(e));
         check("rotate_id", 32'(GNT_ID), 32'((t / 4) % 4));
      end

      // Sole requester 3 is never preempted; dropping REQ idles next cycle.
      for (int t = 0; t < 12; t++) begin
         tick(4'b1000);
         check("sole_gnt", 32'(GNT), 32'b1000);
      end
      tick(4'b0000);
      check("sole_drop", 32'(GNT), 32'd0);
      check("sole_drop_valid", 32'(GNT_VALID), 32'd0);

      // Zero-bubble handover from 0 to 2, then 2 holds to timeout and 0 returns.
      tick(4'b0101);
      check("hand_first", 32'(GNT), 32'b0001);
      tick(4'b0101);
      check("hand_hold", 32'(GNT), 32'b0001);
      tick(4'b0100);
      check("hand_over", 32'(GNT), 32'b0100);
      for (int t = 0; t < 3; t++) begin
         tick(4'b0101);
         check("hand_keep2", 32'(GNT), 32'b0100);
      end
      tick(4'b0101);
      check("hand_timeout", 32'(GNT), 32'b0001);
      tick(4'b0000);
      check("hand_idle", 32'(GNT), 32'd0);

      // 1 then 3; re-request from 1 waits for 3's timeout.
      tick(4'b1010);
      check("rereq_first", 32'(GNT), 32'b0010);
      tick(4'b1000);
      check("rereq_release", 32'(GNT), 32'b1000);
      for (int t = 0; t < 3; t++) begin
         tick(4'b1010);
         check("rereq_wait", 32'(GNT), 32'b1000);
      end
      tick(4'b1010);
      check("rereq_timeout", 32'(GNT), 32'b0010);
      check("rereq_id", 32'(GNT_ID), 32'd1);
      tick(4'b0000);
      check("rereq_idle", 32'(GNT), 32'd0);

      // Reset in the second cycle of a grant to 1 drops outputs without a clock.
      tick(4'b0010);
      check("mid_first", 32'(GNT), 32'b0010);
      tick(4'b1111);
      check("mid_second", 32'(GNT), 32'b0010);
      #1;
      rst = 1'b1;
      #1;
      check("async_gnt", 32'(GNT), 32'd0);
      check("async_valid", 32'(GNT_VALID), 32'd0);
      check("async_id", 32'(GNT_ID), 32'd0);
      tick(4'b1111);
      tick(4'b1111);
      @(negedge clk);
      rst = 1'b0;
      REQ = 4'b1111;
      @(posedge clk);
      #2;
      check("post_reset_gnt", 32'(GNT), 32'b0001);
      check("post_reset_id", 32'(GNT_ID), 32'd0);
      repeat (6) tick(4'b1111);
      check("post_reset_rot", 32'(GNT), 32'b0010);
      tick(4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
